// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment driver.
// Segment encoding is gfedcba, active-low (common-anode digits).
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment pattern decode.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed common-anode 7-segment driver: slot scanner with dead time,
// double-buffered display data, leading-zero suppression, blink and decimal points.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYC     = 50000,
  parameter int DEAD_CYC     = 500,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic [4*NUM_DIGITS-1:0]   iDIG,
  input  logic [NUM_DIGITS-1:0]     iON_OFF,
  input  logic [NUM_DIGITS-1:0]     iBLINK,
  input  logic [NUM_DIGITS-1:0]     iDP,
  input  logic                      iLZ_EN,
  input  logic                      iLOAD,
  output logic                      oREADY,
  output logic                      oLOAD_ACK,
  output logic                      oFRAME,
  output logic [6:0]                oSEG,
  output logic                      oDP,
  output logic [NUM_DIGITS-1:0]     oDIG_SEL
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYC - 1);
  localparam logic [IW-1:0] DIG_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  if (NUM_DIGITS < 2) begin : g_bad_num_digits
    $error("seg7_scan_drv: NUM_DIGITS must be at least 2");
  end
  if (DEAD_CYC < 1 || DEAD_CYC >= SLOT_CYC) begin : g_bad_dead_cyc
    $error("seg7_scan_drv: DEAD_CYC must satisfy 1 <= DEAD_CYC < SLOT_CYC");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("seg7_scan_drv: BLINK_FRAMES must be at least 1");
  end

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0]   on;
    logic [NUM_DIGITS-1:0]   blink;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    lz;
  } disp_t;

  disp_t                 stage_q, stage_d, active_q, active_d;
  logic                  pending_q, pending_d;
  scan_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  phase_q, phase_d;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  ready_q, ack_q, frm_q;

  logic                  last_cyc, frame_end, load_fire, commit;
  logic                  frm_nxt, ack_nxt, sup, lit;
  logic [NUM_DIGITS:0]   zero_up;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;

  always_comb begin
    last_cyc  = (cnt_q == SLOT_LAST);
    frame_end = last_cyc && (idx_q == DIG_LAST);
    load_fire = iLOAD && ready_q;
    commit    = frame_end && pending_q;

    cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (last_cyc) begin
      idx_d = (idx_q == DIG_LAST) ? '0 : idx_q + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == DEAD_LAST) state_d = DRIVE;
      DRIVE:   if (last_cyc)           state_d = BLANK;
      default: state_d = BLANK;
    endcase

    // Load and commit are exclusive: load needs pending clear, commit needs it set.
    stage_d   = load_fire ? disp_t'{iDIG, iON_OFF, iBLINK, iDP, iLZ_EN} : stage_q;
    active_d  = commit ? stage_q : active_q;
    pending_d = load_fire || (pending_q && !commit);

    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (frame_q == BLINK_LAST) begin
        frame_d = '0;
        phase_d = !phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // Outputs are registered, so they are derived from the next-cycle state.
    frm_nxt = (cnt_d == SLOT_LAST) && (idx_d == DIG_LAST);
    ack_nxt = frm_nxt && pending_d;

    zero_up = '0;
    zero_up[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_up[k] = zero_up[k+1] && (active_d.dig[4*k +: 4] == 4'h0);
    end

    nib = active_d.dig[4*idx_d +: 4];
    sup = active_d.lz && (idx_d != '0) && zero_up[idx_d];
    lit = active_d.on[idx_d] && !(active_d.blink[idx_d] && phase_d) && !sup;
  end

  seg7_hex_dec u_hex_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stage_q   <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      phase_q   <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      sel_q     <= '0;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      phase_q   <= phase_d;
      seg_q     <= lit ? dec_seg : SEG_OFF;
      dp_q      <= lit ? !active_d.dp[idx_d] : 1'b1;
      sel_q     <= (state_d == DRIVE) ? (NUM_DIGITS'(1) << idx_d) : '0;
      ready_q   <= !pending_d;
      ack_q     <= ack_nxt;
      frm_q     <= frm_nxt;
    end
  end

  assign oSEG      = seg_q;
  assign oDP       = dp_q;
  assign oDIG_SEL  = sel_q;
  assign oREADY    = ready_q;
  assign oLOAD_ACK = ack_q;
  assign oFRAME    = frm_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Self-checking bench for seg7_scan_drv: table-driven display frames plus
// hand-written sequences for blink, load/commit collisions and mid-scan reset.
`timescale 1ns/1ps
module tb_seg7_scan_drv;

  localparam int N     = 4;
  localparam int SLOT  = 20;
  localparam int DEAD  = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] iDIG = '0;
  logic [3:0]  iON_OFF = '0, iBLINK = '0, iDP = '0;
  logic        iLZ_EN = 1'b0, iLOAD = 1'b0;
  logic        oREADY, oLOAD_ACK, oFRAME, oDP;
  logic [6:0]  oSEG;
  logic [3:0]  oDIG_SEL;

  seg7_scan_drv #(
    .NUM_DIGITS   (N),
    .SLOT_CYC     (SLOT),
    .DEAD_CYC     (DEAD),
    .BLINK_FRAMES (BF)
  ) dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iDIG      (iDIG),
    .iON_OFF   (iON_OFF),
    .iBLINK    (iBLINK),
    .iDP       (iDP),
    .iLZ_EN    (iLZ_EN),
    .iLOAD     (iLOAD),
    .oREADY    (oREADY),
    .oLOAD_ACK (oLOAD_ACK),
    .oFRAME    (oFRAME),
    .oSEG      (oSEG),
    .oDP       (oDP),
    .oDIG_SEL  (oDIG_SEL)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; position in the scan follows from it.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0]     dig;
    logic [3:0]      on;
    logic [3:0]      blink;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t tbl [8];
  vec_t vb, vd;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mkv(input logic [15:0] d, input logic [3:0] on,
                               input logic [3:0] bl, input logic [3:0] dp,
                               input logic lz, input logic [27:0] seg,
                               input logic [3:0] dpo);
    vec_t v;
    v.dig = d; v.on = on; v.blink = bl; v.dp = dp; v.lz = lz;
    v.seg = seg; v.dpo = dpo;
    return v;
  endfunction

  function automatic logic [3:0] exp_sel(input int c);
    if ((c % SLOT) < DEAD) return 4'b0000;
    return 4'(1 << ((c / SLOT) % N));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event, expected one within bound (cycle %0d)", nm, cyc);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_load(input vec_t v);
    int t;
    @(negedge clk);
    iDIG = v.dig; iON_OFF = v.on; iBLINK = v.blink; iDP = v.dp; iLZ_EN = v.lz;
    iLOAD = 1'b1;
    t = 0;
    while (oREADY !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("ready_wait");
    @(negedge clk);
    iLOAD = 1'b0;
    iDIG = ~v.dig; iON_OFF = ~v.on; iDP = ~v.dp; iLZ_EN = ~v.lz;
    chk("ready_drop", 32'(oREADY), 32'd0);
  endtask

  task automatic wait_ack(output int at);
    int t;
    t = 0;
    while (oLOAD_ACK !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    at = cyc;
    if (t >= 400) timeout("ack_wait");
    else chk("ack_pos", 32'(at % FRAME), 32'(FRAME - 1));
    @(negedge clk);
    chk("ack_pulse", 32'(oLOAD_ACK), 32'd0);
  endtask

  // Checks one frame starting at cycle 'base': the segment bus during the
  // dead time and during the enable, for every digit, blink phase applied.
  task automatic check_frame(input vec_t v, input int base);
    logic       ph;
    logic [6:0] es;
    logic       ed;
    ph = (((base / FRAME) / BF) % 2) == 1;
    for (int k = 0; k < N; k++) begin
      es = v.seg[k];
      ed = v.dpo[k];
      if (v.blink[k] && ph) begin
        es = 7'h7F;
        ed = 1'b1;
      end
      wait_until(base + k * SLOT + 1);
      chk($sformatf("blank_sel_d%0d", k), 32'(oDIG_SEL), 32'd0);
      chk($sformatf("blank_seg_d%0d", k), 32'(oSEG), 32'(es));
      wait_until(base + k * SLOT + 10);
      chk($sformatf("drive_sel_d%0d", k), 32'(oDIG_SEL), 32'(1 << k));
      chk($sformatf("drive_seg_d%0d", k), 32'(oSEG), 32'(es));
      chk($sformatf("drive_dp_d%0d", k), 32'(oDP), 32'(ed));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of test before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, t, tgt;

    tbl[0] = mkv(16'h12AF, 4'hF, 4'h0, 4'h0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111);
    tbl[1] = mkv(16'h0030, 4'hF, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111);
    tbl[2] = mkv(16'h0000, 4'hF, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
    tbl[3] = mkv(16'h8421, 4'hA, 4'h0, 4'h6, 1'b0, {7'h00, 7'h7F, 7'h24, 7'h7F}, 4'b1101);
    tbl[4] = mkv(16'h0500, 4'hF, 4'h0, 4'hF, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h40}, 4'b1000);
    tbl[5] = mkv(16'h0004, 4'hF, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h19}, 4'b1111);
    tbl[6] = mkv(16'h7BC9, 4'hF, 4'h0, 4'h1, 1'b0, {7'h78, 7'h03, 7'h46, 7'h10}, 4'b1110);
    tbl[7] = mkv(16'hED36, 4'hF, 4'h0, 4'h0, 1'b1, {7'h06, 7'h21, 7'h30, 7'h02}, 4'b1111);
    vb     = mkv(16'h1234, 4'hF, 4'h1, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
    vd     = mkv(16'h9E5B, 4'hF, 4'h0, 4'h4, 1'b0, {7'h10, 7'h06, 7'h12, 7'h03}, 4'b1011);

    // Reset values
    #23;
    chk("rst_seg", 32'(oSEG), 32'h7F);
    chk("rst_dp", 32'(oDP), 32'd1);
    chk("rst_sel", 32'(oDIG_SEL), 32'd0);
    chk("rst_ready", 32'(oREADY), 32'd1);
    chk("rst_ack", 32'(oLOAD_ACK), 32'd0);
    chk("rst_frame", 32'(oFRAME), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scanning with nothing loaded: dark bus, enables still sweep
    repeat (200) begin
      @(negedge clk);
      chk("idle_seg", 32'(oSEG), 32'h7F);
      chk("idle_dp", 32'(oDP), 32'd1);
      chk("idle_sel", 32'(oDIG_SEL), 32'(exp_sel(cyc)));
      chk("idle_frame", 32'(oFRAME), 32'((cyc % FRAME) == FRAME - 1));
    end

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i]);
      wait_ack(a);
      check_frame(tbl[i], a + 1);
    end

    // Blink on digit 0 across four frames: two lit, two dark
    do_load(vb);
    wait_ack(a);
    for (int f = 0; f < 4; f++) check_frame(vb, a + 1 + f * FRAME);

    // Load captured on the frame-end cycle with pending clear commits one frame later
    tgt = (cyc / FRAME) * FRAME + FRAME - 1;
    if (tgt <= cyc) tgt += FRAME;
    wait_until(tgt);
    iDIG = vd.dig; iON_OFF = vd.on; iBLINK = vd.blink; iDP = vd.dp; iLZ_EN = vd.lz;
    iLOAD = 1'b1;
    chk("edge_ready", 32'(oREADY), 32'd1);
    chk("edge_no_ack", 32'(oLOAD_ACK), 32'd0);
    @(negedge clk);
    iLOAD = 1'b0;
    chk("edge_captured", 32'(oREADY), 32'd0);
    wait_ack(a);
    chk("edge_commit_cyc", 32'(a), 32'(tgt + FRAME));
    check_frame(vd, a + 1);

    // Second load while pending, held through the commit cycle, is ignored
    do_load(tbl[6]);
    @(negedge clk);
    iDIG = tbl[7].dig; iON_OFF = tbl[7].on; iBLINK = tbl[7].blink;
    iDP = tbl[7].dp; iLZ_EN = tbl[7].lz;
    iLOAD = 1'b1;
    chk("busy_ready", 32'(oREADY), 32'd0);
    t = 0;
    while (oLOAD_ACK !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    a = cyc;
    if (t >= 400) timeout("busy_ack_wait");
    else chk("busy_ack_pos", 32'(a % FRAME), 32'(FRAME - 1));
    chk("commit_ready", 32'(oREADY), 32'd0);
    @(negedge clk);
    iLOAD = 1'b0;
    chk("ready_rise", 32'(oREADY), 32'd1);
    check_frame(tbl[6], a + 1);
    wait_until(a + FRAME);
    chk("no_recommit", 32'(oLOAD_ACK), 32'd0);
    chk("ready_idle", 32'(oREADY), 32'd1);

    // Reset during digit 2 drive with a load pending
    do_load(tbl[1]);
    wait_until(a + FRAME + 1 + 2 * SLOT + 10);
    chk("pre_rst_sel", 32'(oDIG_SEL), 32'b0100);
    chk("pre_rst_seg", 32'(oSEG), 32'(tbl[6].seg[2]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(oSEG), 32'h7F);
    chk("arst_dp", 32'(oDP), 32'd1);
    chk("arst_sel", 32'(oDIG_SEL), 32'd0);
    chk("arst_ready", 32'(oREADY), 32'd1);
    chk("arst_ack", 32'(oLOAD_ACK), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) begin
      @(negedge clk);
      chk("post_rst_seg", 32'(oSEG), 32'h7F);
      chk("post_rst_ack", 32'(oLOAD_ACK), 32'd0);
      chk("post_rst_sel", 32'(oDIG_SEL), 32'(exp_sel(cyc)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
